// File: rtl/seg7_scan.sv
// Multiplexed 4-digit seven-segment scanner with per-slot blanking, frame-boundary data
// latching, per-digit decimal points and optional leading-zero suppression.
module seg7_scan #(
  parameter int unsigned CLKFREQ          = 27000000,
  parameter int unsigned SCAN_HZ          = 1000,
  parameter int unsigned BLANK_CYCLES     = 64,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dat,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  input  logic        enable,
  output logic [3:0]  digits,
  output logic [7:0]  segments,
  output logic        frame_tick
);

  localparam int unsigned DIV = CLKFREQ / SCAN_HZ;
  localparam int unsigned SW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(DIV - 1);
  localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYCLES);

  if (DIV < BLANK_CYCLES + 2) begin : gen_bad_params
    $error("seg7_scan: CLKFREQ/SCAN_HZ must be at least BLANK_CYCLES+2");
  end

  logic [SW-1:0] slot_cnt_q;
  logic [1:0]    idx_q;
  logic [15:0]   dat_q;
  logic [3:0]    dp_q;
  logic          frame_tick_q;
  logic [3:0]    digits_q;
  logic [7:0]    segments_q;

  logic          slot_last;
  logic          frame_wrap;
  logic [3:0]    nib;
  logic [6:0]    pat;
  logic          sup;
  logic          show;
  logic [3:0]    dig_hi;
  logic [7:0]    seg_hi;

  assign slot_last  = (slot_cnt_q == SLOT_LAST);
  assign frame_wrap = slot_last && (idx_q == 2'd3);
  assign nib        = dat_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    pat = 7'h00;
    unique case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
  end

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    sup = 1'b0;
    unique case (idx_q)
      2'd0: sup = 1'b0;
      2'd1: sup = (dat_q[15:4] == 12'h000);
      2'd2: sup = (dat_q[15:8] == 8'h00);
      2'd3: sup = (dat_q[15:12] == 4'h0);
      default: sup = 1'b0;
    endcase
    sup = sup && lz_en;
  end

  always_comb begin
    show   = enable && (slot_cnt_q >= BLANK_END) && (!sup || dp_q[idx_q]);
    dig_hi = 4'h0;
    seg_hi = 8'h00;
    if (show) begin
      dig_hi = 4'b0001 << idx_q;
      seg_hi = {dp_q[idx_q], sup ? 7'h00 : pat};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q   <= '0;
      idx_q        <= 2'd0;
      dat_q        <= 16'h0000;
      dp_q         <= 4'h0;
      frame_tick_q <= 1'b0;
      digits_q     <= {4{DIGIT_ACTIVE_LOW}};
      segments_q   <= {8{SEG_ACTIVE_LOW}};
    end else begin
      slot_cnt_q   <= slot_last ? '0 : slot_cnt_q + 1'b1;
      if (slot_last) idx_q <= idx_q + 2'd1;
      if (frame_wrap) begin
        dat_q <= dat;
        dp_q  <= dp_in;
      end
      frame_tick_q <= frame_wrap;
      digits_q     <= dig_hi ^ {4{DIGIT_ACTIVE_LOW}};
      segments_q   <= seg_hi ^ {8{SEG_ACTIVE_LOW}};
    end
  end

  assign digits     = digits_q;
  assign segments   = segments_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: per-cycle reference-model scoreboard, a table of frame-level display
// vectors, and hand-written reset / enable / mid-frame sequences.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dat;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic        enable;
  logic [3:0]  digits;
  logic [7:0]  segments;
  logic        frame_tick;

  int vectors = 0;
  int miscompares = 0;

  seg7_scan #(
    .CLKFREQ         (1000),
    .SCAN_HZ         (100),
    .BLANK_CYCLES    (2),
    .DIGIT_ACTIVE_LOW(1'b1),
    .SEG_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dat       (dat),
    .dp_in     (dp_in),
    .lz_en     (lz_en),
    .enable    (enable),
    .digits    (digits),
    .segments  (segments),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: position in the scan is just a cycle count since reset.
  logic [6:0]  hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int unsigned s;
  logic [15:0] sh_dat;
  logic [3:0]  sh_dp;
  logic [3:0]  m_dig;
  logic [7:0]  m_seg;
  logic        m_tick;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    int unsigned slot, d;
    logic [15:0] upper;
    logic        sup;
    logic [3:0]  hi_dig;
    logic [7:0]  hi_seg;
    if (rst) begin
      m_dig = 4'hF; m_seg = 8'hFF; m_tick = 1'b0;
      s = 0; sh_dat = 16'h0; sh_dp = 4'h0; m_valid = 1'b1;
    end else if (m_valid) begin
      slot  = s % 10;
      d     = (s / 10) % 4;
      upper = sh_dat >> (4 * d);
      sup   = lz_en && (d != 0) && (upper == 16'h0);
      if (!enable || slot < 2 || (sup && !sh_dp[d])) begin
        hi_dig = 4'h0;
        hi_seg = 8'h00;
      end else begin
        hi_dig = 4'(1 << d);
        hi_seg = {sh_dp[d], sup ? 7'h00 : hex7[upper[3:0]]};
      end
      m_dig  = ~hi_dig;
      m_seg  = ~hi_seg;
      m_tick = (s % 40 == 39);
      if (m_tick) begin
        sh_dat = dat;
        sh_dp  = dp_in;
      end
      s = s + 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      vectors++;
      if ({digits, segments, frame_tick} !== {m_dig, m_seg, m_tick}) begin
        miscompares++;
        $display("FAIL model t=%0t: got dig=%h seg=%h tick=%b, want dig=%h seg=%h tick=%b",
                 $time, digits, segments, frame_tick, m_dig, m_seg, m_tick);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_tick t=%0t: got no frame_tick, want one within 100 cycles", $time);
    end
  endtask

  typedef struct {
    logic [15:0]      dat;
    logic [3:0]       dp;
    logic             lz;
    logic [3:0]       on;
    logic [3:0][7:0]  seg;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int ticks;
    tbl[0] = '{16'h1234, 4'b0000, 1'b0, 4'b1111, 32'hF9A4B099};
    tbl[1] = '{16'h0005, 4'b0000, 1'b1, 4'b0001, 32'hFFFFFF92};
    tbl[2] = '{16'h0000, 4'b0100, 1'b1, 4'b0101, 32'hFF7FFFC0};
    tbl[3] = '{16'h0000, 4'b0000, 1'b0, 4'b1111, 32'hC0C0C0C0};
    tbl[4] = '{16'hABCD, 4'b0000, 1'b0, 4'b1111, 32'h8883C6A1};
    tbl[5] = '{16'h00F0, 4'b0001, 1'b1, 4'b0011, 32'hFFFF8E40};
    tbl[6] = '{16'h8000, 4'b1111, 1'b1, 4'b1111, 32'h00404040};

    rst = 1'b1; dat = 16'h0; dp_in = 4'h0; lz_en = 1'b0; enable = 1'b1;
    skip(3);
    check("reset_digits", {4'h0, digits}, 8'h0F);
    check("reset_segments", segments, 8'hFF);
    check("reset_tick", {7'h0, frame_tick}, 8'h00);
    rst = 1'b0;
    skip(1);
    check("first_blank", {4'h0, digits}, 8'h0F);
    skip(2);
    check("first_digit0", {4'h0, digits}, 8'h0E);
    check("first_seg0", segments, 8'hC0);

    foreach (tbl[t]) begin
      dat = tbl[t].dat; dp_in = tbl[t].dp; lz_en = tbl[t].lz;
      wait_tick();
      for (int k = 0; k < 4; k++) begin
        skip(1);
        check("tbl_blank", {4'h0, digits}, 8'h0F);
        skip(4);
        check("tbl_digits", {4'h0, digits}, tbl[t].on[k] ? {4'h0, ~(4'b0001 << k)} : 8'h0F);
        check("tbl_segments", segments, tbl[t].on[k] ? tbl[t].seg[k] : 8'hFF);
        skip(5);
      end
    end

    // New data arriving mid-frame must not appear until the next boundary.
    dat = 16'h1234; dp_in = 4'h0; lz_en = 1'b0;
    wait_tick();
    skip(15);
    dat = 16'hABCD;
    skip(10);
    check("midframe_d2", segments, 8'hA4);
    skip(10);
    check("midframe_d3", segments, 8'hF9);
    wait_tick();
    skip(5);
    check("midframe_new_d0", segments, 8'hA1);

    // Disabled display still keeps frame timing.
    wait_tick();
    enable = 1'b0;
    ticks = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      check("disabled_digits", {4'h0, digits}, 8'h0F);
      if (frame_tick) ticks++;
    end
    check("disabled_tick_count", 8'(ticks), 8'd1);
    check("disabled_tick_last", {7'h0, frame_tick}, 8'h01);
    enable = 1'b1;

    // Reset during digit 2 slot.
    wait_tick();
    skip(25);
    check("pre_rst_digit2", {4'h0, digits}, 8'h0B);
    rst = 1'b1;
    skip(1);
    check("midrst_digits", {4'h0, digits}, 8'h0F);
    check("midrst_segments", segments, 8'hFF);
    rst = 1'b0;
    skip(1);
    check("post_rst_blank", {4'h0, digits}, 8'h0F);
    skip(2);
    check("post_rst_digit0", {4'h0, digits}, 8'h0E);

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 29) == 0) dat = 16'($urandom);
      if ($urandom_range(0, 29) == 0) dat = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 99) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 149) == 0) enable = ~enable;
    end
    rst = 1'b0;
    skip(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Multiplexed 4-digit seven-segment display driver that consumes the 16-bit value produced by the counter core and drives the board's shared digit-select and segment lines.
- Scans one digit at a time at a fixed per-digit rate, with an anti-ghosting blank interval at the start of each digit slot.
- Loads new display data only at frame boundaries, so a frame never shows a mix of old and new nibbles.
- Supports per-digit decimal points and optional leading-zero suppression.

Parameters:
- CLKFREQ, 27000000: input clock frequency in Hz.
- SCAN_HZ, 1000: digit slot rate in Hz; one full frame is 4 slots.
- BLANK_CYCLES, 64: clocks at the start of each slot during which all digits are off.
- DIGIT_ACTIVE_LOW, 1: 1 means digits[i]=0 enables digit i.
- SEG_ACTIVE_LOW, 1: 1 means segments[j]=0 lights segment j.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- dat  in  16  value to display; nibble k goes to digit k (digit 0 = least significant, rightmost)
- dp_in  in  4  decimal point request per digit
- lz_en  in  1  leading-zero suppression enable
- enable  in  1  display enable; 0 forces all digits off
- digits  out  4  digit select, one-hot when active, polarity per DIGIT_ACTIVE_LOW
- segments  out  8  [0]=a … [6]=g, [7]=dp, polarity per SEG_ACTIVE_LOW
- frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All state changes on rising clk.
- Slot counter and width:
  - DIV = CLKFREQ/SCAN_HZ (integer division).
  - Compile-time check: DIV >= BLANK_CYCLES+2.
  - slot_cnt width = $clog2(DIV). Counts 0..DIV-1, then wraps to 0.
- Digit index:
  - idx is 2 bits, 0..3.
  - Increments when slot_cnt == DIV-1. Wraps 3→0.
- Frame boundary (idx 3→0 wrap):
  - Shadow registers take dat and dp_in.
  - frame_tick=1 for that single cycle, registered.
  - No other shadow loads. Inputs that change mid-frame are ignored until the next boundary.
- Blanking: while slot_cnt < BLANK_CYCLES, all digits are inactive and all segments are off.
- Decode: shadow nibble idx maps to the standard hex pattern a–g. Active-high patterns:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Segment [7] = shadow dp[idx].
- Leading-zero suppression (lz_en=1, evaluated on shadow data):
  - Digit 3 is suppressed if nibble3==0.
  - Digit 2 is suppressed if nibbles 3..2 are all 0.
  - Digit 1 is suppressed if nibbles 3..1 are all 0.
  - Digit 0 is never suppressed.
  - A suppressed digit has a–g off. It is deselected unless its dp is set, in which case it is selected with only dp lit.
- enable=0: slot_cnt, idx and frame_tick keep running; digits are forced inactive and segments off.
- Output timing: digits and segments are registered, one cycle after the slot_cnt/idx state that produces them.
- Reset:
  - slot_cnt=0, idx=0, shadow dat=0, shadow dp=0, frame_tick=0.
  - digits all inactive (4'hF for active-low); segments all off (8'hFF for active-low).
  - Reset mid-scan takes effect on the next edge, with no partial slot completed.
  - First frame after reset displays 0 until the first frame boundary.
- Simultaneous events: rst has priority over everything. A slot wrap coinciding with a frame wrap performs the shadow load and the idx change in the same cycle.

Test Plan:
Bench parameters: CLKFREQ=1000, SCAN_HZ=100 (DIV=10), BLANK_CYCLES=2, active-low outputs.
- Reset: rst=1 for 3 cycles → digits=4'hF, segments=8'hFF, frame_tick=0. After release with dat=0, lz_en=0, digit 0 slot → digits=4'hE, segments=8'hC0.
- Hex scan: dat=16'h1234, dp_in=0, lz_en=0, after the first frame_tick:
  - digit 0 active (digits=E): segments=99
  - digit 1 (D): segments=B0
  - digit 2 (B): segments=A4
  - digit 3 (7): segments=F9
  - Each digit is active for 8 cycles, preceded by 2 blank cycles with digits=F.
- Leading zeros:
  - dat=16'h0005, lz_en=1 → only digit 0 is ever selected, showing 92.
  - dat=0, lz_en=1, dp_in=4'b0100 → digit 2 shows 7F; digit 0 shows C0.
- Mid-frame update: change dat 16'h1234→16'hABCD during the digit 1 slot → digits 2 and 3 still show 2 and 1. After frame_tick, digit 0 shows A1 (d).
- Enable and reset mid-scan:
  - enable=0 for one full frame → digits=F throughout, and frame_tick still pulses every 40 cycles.
  - rst pulse during the digit 2 slot → next cycle outputs are off and idx restarts at digit 0 after release.
